// File: rtl/soc_system_button_in_pio.sv
// Avalon-MM input PIO: 2-flop sync + per-bit debounce + press-edge capture with maskable level irq.
// Latency: stable follows a clean pin change 2+DEBOUNCE_CYCLES clocks later; reads are zero wait state, no backpressure.
module soc_system_button_in_pio #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1, s2;
  logic [WIDTH-1:0] stable, stable_nxt;
  logic [CNT_W-1:0] cnt     [WIDTH];
  logic [CNT_W-1:0] cnt_nxt [WIDTH];
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] press;
  logic [WIDTH-1:0] ec_clr;
  logic             wr_mask;
  logic             wr_ec;

  assign wr_mask = chipselect & ~write_n & (address == 2'd2);
  assign wr_ec   = chipselect & ~write_n & (address == 2'd3);
  assign ec_clr  = wr_ec ? writedata[WIDTH-1:0] : '0;

  // Idle-high pins: sync stages reset to 1 so reset release never looks like a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= in_port;
      s2 <= s1;
    end
  end

  // Any cycle where s2 agrees with stable restarts the run, so glitches shorter than the window vanish.
  always_comb begin
    stable_nxt = stable;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = '0;
      if (s2[i] != stable[i]) begin
        if (cnt[i] == CNT_MAX) begin
          stable_nxt[i] = s2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= '1;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      stable <= stable_nxt;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  assign press = stable & ~stable_nxt;

  // Set beats clear in the same clock so a press landing on a W1C write is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      if (wr_mask) irq_mask <= writedata[WIDTH-1:0];
      edge_capture <= (edge_capture & ~ec_clr) | press;
    end
  end

  assign irq = |(edge_capture & irq_mask);

  always_comb begin
    readdata = '0;
    if (chipselect) begin
      case (address)
        2'd0:    readdata = 32'(stable);
        2'd2:    readdata = 32'(irq_mask);
        2'd3:    readdata = 32'(edge_capture);
        default: readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_system_button_in_pio.sv
// Directed + random bench for soc_system_button_in_pio; reference model uses a sample-history window rule.
module tb_soc_system_button_in_pio;
  localparam int W = 3;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   readdata;
  logic          irq;

  int checks = 0;
  int errors = 0;

  // A pin sample reaches the debouncer two edges later; it is accepted once D consecutive such samples oppose stable.
  logic [W-1:0] hist [D+2];
  logic [W-1:0] m_stable, m_mask, m_ec;

  always #5 clk = ~clk;

  soc_system_button_in_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  task automatic model_reset();
    for (int k = 0; k < D + 2; k++) hist[k] = '1;
    m_stable = '1;
    m_mask   = '0;
    m_ec     = '0;
  endtask

  task automatic model_edge(input logic [W-1:0] pin, input logic cs, input logic wn,
                            input logic [1:0] a, input logic [31:0] wd);
    logic [W-1:0] nstable, press, clr;
    logic         all_opp;
    for (int k = D + 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = pin;
    nstable = m_stable;
    for (int i = 0; i < W; i++) begin
      all_opp = 1'b1;
      for (int j = 2; j < D + 2; j++) if (hist[j][i] == m_stable[i]) all_opp = 1'b0;
      if (all_opp) nstable[i] = ~m_stable[i];
    end
    press = m_stable & ~nstable;
    clr   = (cs && !wn && a == 2'd3) ? wd[W-1:0] : '0;
    m_ec  = (m_ec & ~clr) | press;
    if (cs && !wn && a == 2'd2) m_mask = wd[W-1:0];
    m_stable = nstable;
  endtask

  task automatic step();
    @(posedge clk);
    if (reset_n) model_edge(in_port, chipselect, write_n, address, writedata);
    else         model_reset();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic read_reg(input logic [1:0] a);
    chipselect = 1'b1; write_n = 1'b1; address = a; #1;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp;
    for (int a = 0; a < 4; a++) begin
      read_reg(2'(a));
      case (a)
        0:       exp = 32'(m_stable);
        2:       exp = 32'(m_mask);
        3:       exp = 32'(m_ec);
        default: exp = 32'h0;
      endcase
      chk($sformatf("%s_rd%0d", tag, a), readdata, exp);
    end
    chipselect = 1'b0; #1;
    chk({tag, "_idle"}, readdata, 32'h0);
    chk({tag, "_irq"}, {31'h0, irq}, {31'h0, |(m_ec & m_mask)});
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    step();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  initial begin
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = 3'b000;
    model_reset();

    // Reset: pins low but held in reset
    repeat (3) step();
    check_all("reset");
    read_reg(2'd0); chk("reset_data", readdata, 32'h7);
    chipselect = 1'b0;

    in_port = 3'b111;
    reset_n = 1'b1;
    repeat (3) step();
    check_all("idle");

    // Glitch: two 3-clock lows separated by one high clock must not be accepted
    in_port = 3'b101; repeat (3) step();
    in_port = 3'b111; step();
    in_port = 3'b101; repeat (3) step();
    in_port = 3'b111;
    repeat (8) begin step(); check_all("glitch"); end
    read_reg(2'd0); chk("glitch_data", readdata, 32'h7);
    read_reg(2'd3); chk("glitch_ec", readdata, 32'h0);

    // Clean press on bit 0: visible on the 6th edge counting the sampling edge
    in_port = 3'b110;
    for (int k = 1; k <= 6; k++) begin
      step();
      read_reg(2'd0); chk($sformatf("press_data_k%0d", k), readdata, (k < 6) ? 32'h7 : 32'h6);
      read_reg(2'd3); chk($sformatf("press_ec_k%0d", k), readdata, (k < 6) ? 32'h0 : 32'h1);
      chipselect = 1'b0; #1;
      chk("press_irq", {31'h0, irq}, 32'h0);
      check_all("press");
    end

    // Interrupt flow
    wr(2'd2, 32'h1); check_all("mask_on");
    chk("irq_on", {31'h0, irq}, 32'h1);
    wr(2'd2, 32'h0); check_all("mask_off");
    chk("irq_masked", {31'h0, irq}, 32'h0);
    read_reg(2'd3); chk("ec_retained", readdata, 32'h1);
    wr(2'd2, 32'h1); check_all("mask_reon");
    chk("irq_reon", {31'h0, irq}, 32'h1);
    wr(2'd3, 32'h2); check_all("w1c_other");
    read_reg(2'd3); chk("w1c_other_ec", readdata, 32'h1);
    wr(2'd3, 32'h1); check_all("w1c_bit0");
    chk("irq_cleared", {31'h0, irq}, 32'h0);

    // Collision: W1C of bit 2 lands on the edge bit 2 is captured
    wr(2'd2, 32'h4);
    in_port = 3'b010;
    repeat (5) step();
    chipselect = 1'b1; write_n = 1'b0; address = 2'd3; writedata = 32'h4;
    step();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    check_all("collide");
    read_reg(2'd3); chk("collide_ec", readdata, 32'h4);
    chipselect = 1'b0; #1;
    chk("collide_irq", {31'h0, irq}, 32'h1);

    // Reset mid-debounce on a bit-0 press
    in_port = 3'b111;
    repeat (8) step();
    wr(2'd3, 32'h7);
    in_port = 3'b110;
    repeat (2) step();
    reset_n = 1'b0; model_reset(); #1;
    check_all("arst_async");
    repeat (2) step();
    in_port = 3'b111;
    reset_n = 1'b1;
    repeat (10) step();
    check_all("arst_after");
    read_reg(2'd0); chk("arst_data", readdata, 32'h7);
    read_reg(2'd3); chk("arst_ec", readdata, 32'h0);
    chipselect = 1'b0;

    // Random pins and bus writes against the model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(5) == 0) in_port = W'($urandom);
      if ($urandom_range(7) == 0) begin
        chipselect = 1'b1; write_n = 1'b0;
        address = 2'($urandom); writedata = $urandom;
      end
      step();
      chipselect = 1'b0; write_n = 1'b1; writedata = '0;
      check_all("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
